// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder. The operands are captured on an accepted start. A single
//   full-adder cell then processes one bit per clock, LSB first. The sum,
//   carry-out and signed overflow are published together on completion, and
//   done pulses for one cycle at that point.
//
//   Optional feature macro: SERIAL_ADDER_SUB_EN
//     When defined, the module gains a 'sub' input that selects a-b.
//     Subtraction loads ~b and forces the carry register to 1, so cin is
//     ignored. cout=1 then means "no borrow".
//
// Parameters
//   WIDTH  operand/result width (2..64)
//
// Ports
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  begin an addition (accepted in IDLE or DONE only)
//   a, b   operands, captured on accepted start
//   cin    carry-in, captured on accepted start
//   sub    (SERIAL_ADDER_SUB_EN only) subtract select, captured on start
//   busy   high while bits are being processed
//   done   one-cycle pulse when sum/cout/ovf have just been updated
//   sum    registered result, held until the next completion
//   cout   registered carry out of the MSB
//   ovf    registered two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept_c;
  logic             last_c;
  logic             bit_s_c;
  logic             bit_c_c;
  logic [WIDTH-1:0] b_load_c;
  logic             c_load_c;

  // Operand B and the initial carry as they are loaded on an accepted start
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load_c = b;
    c_load_c = cin;
    if (sub) begin
      b_load_c = ~b;
      c_load_c = 1'b1;
    end
  end
`else
  always_comb begin
    b_load_c = b;
    c_load_c = cin;
  end
`endif

  // The single full-adder cell, fed from the LSBs of the shift registers
  always_comb begin
    bit_s_c = a_sh[0] ^ b_sh[0] ^ carry;
    bit_c_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic and the accept/last strobes
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // start is ignored here; the operation in flight runs to completion
        if (cnt == CW'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Back-to-back start goes straight to RUN with no dead cycle
        if (start) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: shift registers, bit counter and the published result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= last_c;
      if (accept_c) begin
        a_sh   <= a;
        b_sh   <= b_load_c;
        carry  <= c_load_c;
        res_sh <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        carry  <= bit_c_c;
        res_sh <= {bit_s_c, res_sh[WIDTH-1:1]};
        cnt    <= cnt + CW'(1);
        if (last_c) begin
          // On the MSB step, carry holds the carry into the MSB and
          // bit_c_c holds the carry out of it
          sum  <= {bit_s_c, res_sh[WIDTH-1:1]};
          cout <= bit_c_c;
          ovf  <= carry ^ bit_c_c;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed, table-driven bench for serial_adder at WIDTH=8 in the default
//   build (addition only). Inputs are driven and outputs sampled on the
//   falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Count falling edges from the current one until done is seen. lat=1 means
  // done is already high at entry. Optionally scramble operands meanwhile.
  task automatic wait_done(input bit scramble, output int lat, output int busy_cnt,
                           output bit sum_moved);
    logic [7:0] sum0;
    sum0      = sum;
    lat       = 1;
    busy_cnt  = 0;
    sum_moved = 1'b0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (sum !== sum0) sum_moved = 1'b1;
      if (scramble) begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL wait_done: timeout, done never rose within %0d cycles", lat);
    end
  endtask

  // One complete operation from an idle start
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int bc;
    bit moved;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b1, lat, bc, moved);
    check($sformatf("v%0d latency", idx), 64'(lat), 64'd9);
    check($sformatf("v%0d busy_cycles", idx), 64'(bc), 64'd8);
    check($sformatf("v%0d sum_stable", idx), 64'(moved), 64'd0);
    check($sformatf("v%0d sum", idx), 64'(sum), 64'(v.sum));
    check($sformatf("v%0d cout", idx), 64'(cout), 64'(v.cout));
    check($sformatf("v%0d ovf", idx), 64'(ovf), 64'(v.ovf));
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
    check($sformatf("v%0d busy_after", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    vec_t vecs[9];
    int lat;
    int bc;
    bit moved;
    int done_seen;

    vecs[0] = '{a:8'h0F, b:8'h01, cin:1'b0, sum:8'h10, cout:1'b0, ovf:1'b0};
    vecs[1] = '{a:8'hFF, b:8'h01, cin:1'b0, sum:8'h00, cout:1'b1, ovf:1'b0};
    vecs[2] = '{a:8'h7F, b:8'h01, cin:1'b0, sum:8'h80, cout:1'b0, ovf:1'b1};
    vecs[3] = '{a:8'h80, b:8'h80, cin:1'b0, sum:8'h00, cout:1'b1, ovf:1'b1};
    vecs[4] = '{a:8'hFF, b:8'hFF, cin:1'b1, sum:8'hFF, cout:1'b1, ovf:1'b0};
    vecs[5] = '{a:8'h00, b:8'h00, cin:1'b1, sum:8'h01, cout:1'b0, ovf:1'b0};
    vecs[6] = '{a:8'h55, b:8'hAA, cin:1'b0, sum:8'hFF, cout:1'b0, ovf:1'b0};
    vecs[7] = '{a:8'h55, b:8'hAA, cin:1'b1, sum:8'h00, cout:1'b1, ovf:1'b0};
    vecs[8] = '{a:8'h40, b:8'h40, cin:1'b0, sum:8'h80, cout:1'b0, ovf:1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    // Table-driven vectors; operands are scrambled during RUN
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // start held high through RUN (ignored), then through DONE (back-to-back)
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h22; b = 8'h33;
    wait_done(1'b0, lat, bc, moved);
    check("b2b first latency", 64'(lat), 64'd9);
    check("b2b first sum", 64'(sum), 64'h10);
    @(negedge clk);
    start = 1'b0;
    check("b2b no_idle busy", 64'(busy), 64'd1);
    check("b2b done_low", 64'(done), 64'd0);
    check("b2b sum_held", 64'(sum), 64'h10);
    wait_done(1'b1, lat, bc, moved);
    check("b2b second latency", 64'(lat), 64'd9);
    check("b2b second busy_cycles", 64'(bc), 64'd8);
    check("b2b second sum", 64'(sum), 64'h55);
    check("b2b second cout", 64'(cout), 64'd0);

    // Reset in the middle of RUN: outputs clear at once, no done pulse
    run_vec(vecs[2], 100);
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async sum", 64'(sum), 64'd0);
    check("rst_async ovf", 64'(ovf), 64'd0);
    check("rst_async busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst no_done", 64'(done_seen), 64'd0);
    check("rst idle busy", 64'(busy), 64'd0);
    run_vec('{a:8'h03, b:8'h04, cin:1'b0, sum:8'h07, cout:1'b0, ovf:1'b0}, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
